up_down_counter_param: RTL

Parametrised successor to the 4-bit loadable up-counter: a WIDTH-bit modulo-MODULUS counter with up/down direction, wrap or saturate mode, synchronous clear and parallel load. Provides a combinational terminal-count flag plus registered one-cycle wrap/saturation event pulses. Used as the generic datapath counter in timers, address generators and loop controllers.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_next_logic.sv | 78 +++++++
 rtl/up_down_counter_param.sv | 68 ++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Largest count value reachable for a given number of states.
   function automatic int max_val(input int modulus);
      return modulus - 1;
   endfunction

endpackage

// File: rtl/counter_next_logic.sv
// Combinational next-count and event decode for the up/down counter.
module counter_next_logic
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2 ** WIDTH
) (
   input  logic [WIDTH-1:0] count_q,
   input  logic [WIDTH-1:0] in,
   input  logic             ld,
   input  logic             clr,
   input  logic             cnt,
   input  logic             up,
   input  logic             sat,
   output logic [WIDTH-1:0] count_d,
   output logic             wrap_d,
   output logic             sat_hit_d,
   output logic             ld_err_d,
   output logic             tcount
);

   // One extra bit keeps MODULUS-1 and in >= MODULUS comparisons exact at full range.
   localparam logic [WIDTH:0] MAX_W = (WIDTH + 1)'(max_val(MODULUS));
   localparam logic [WIDTH:0] ONE_W = (WIDTH + 1)'(1);

   logic [WIDTH:0] count_ext;
   logic [WIDTH:0] in_ext;
   logic [WIDTH:0] inc_ext;
   logic [WIDTH:0] dec_ext;
   logic           at_max;
   logic           at_zero;

   assign count_ext = {1'b0, count_q};
   assign in_ext    = {1'b0, in};
   assign inc_ext   = count_ext + ONE_W;
   assign dec_ext   = count_ext - ONE_W;
   assign at_max    = (count_ext == MAX_W);
   assign at_zero   = (count_ext == '0);
   assign tcount    = (up == DIR_UP) ? at_max : at_zero;

   always_comb begin
      count_d   = count_q;
      wrap_d    = 1'b0;
      sat_hit_d = 1'b0;
      ld_err_d  = 1'b0;
      if (clr) begin
         count_d = '0;
      end else if (ld) begin
         if (in_ext > MAX_W) begin
            count_d  = MAX_W[WIDTH-1:0];
            ld_err_d = 1'b1;
         end else begin
            count_d = in;
         end
      end else if (cnt) begin
         if (up == DIR_UP) begin
            if (!at_max) begin
               count_d = inc_ext[WIDTH-1:0];
            end else if (sat == MODE_SAT) begin
               sat_hit_d = 1'b1;
            end else begin
               count_d = '0;
               wrap_d  = 1'b1;
            end
         end else if (up == DIR_DOWN) begin
            if (!at_zero) begin
               count_d = dec_ext[WIDTH-1:0];
            end else if (sat == MODE_WRAP) begin
               count_d = MAX_W[WIDTH-1:0];
               wrap_d  = 1'b1;
            end else begin
               sat_hit_d = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/up_down_counter_param.sv
// WIDTH-bit modulo-MODULUS up/down counter with wrap/saturate mode, clear and load.
module up_down_counter_param
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2 ** WIDTH,
   parameter int RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             ld,
   input  logic             clr,
   input  logic             cnt,
   input  logic             up,
   input  logic             sat,
   output logic [WIDTH-1:0] count,
   output logic             tcount,
   output logic             wrap,
   output logic             sat_hit,
   output logic             ld_err
);

   localparam logic [WIDTH-1:0] RST_VAL_W = WIDTH'(RST_VAL);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             sat_hit_q, sat_hit_d;
   logic             ld_err_q, ld_err_d;

   counter_next_logic #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .count_q   (count_q),
      .in        (in),
      .ld        (ld),
      .clr       (clr),
      .cnt       (cnt),
      .up        (up),
      .sat       (sat),
      .count_d   (count_d),
      .wrap_d    (wrap_d),
      .sat_hit_d (sat_hit_d),
      .ld_err_d  (ld_err_d),
      .tcount    (tcount)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= RST_VAL_W;
         wrap_q    <= 1'b0;
         sat_hit_q <= 1'b0;
         ld_err_q  <= 1'b0;
      end else begin
         count_q   <= count_d;
         wrap_q    <= wrap_d;
         sat_hit_q <= sat_hit_d;
         ld_err_q  <= ld_err_d;
      end
   end

   assign count   = count_q;
   assign wrap    = wrap_q;
   assign sat_hit = sat_hit_q;
   assign ld_err  = ld_err_q;

endmodule
